// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for a 4-digit common-anode
//             seven-segment display. It drives one active-low anode at a
//             time with its active-low segment pattern. New content is
//             staged through a load strobe and becomes visible only at a
//             frame boundary, so a frame never shows mixed content.
//  Ports    : clk        - system clock, rising edge
//             rst_n      - asynchronous active-low reset
//             value_i    - display word, nibble k -> digit k (0 = rightmost)
//             dp_i       - decimal-point request per digit (1 = lit)
//             en_i       - digit enable per digit (1 = may light)
//             lzb_i      - leading-zero blanking enable
//             load_i     - 1-cycle strobe capturing the four inputs above
//             load_ack_o - pulse when captured content becomes visible
//             frame_o    - pulse at every frame boundary
//             sseg_o     - active-low segments, bit7 = dp, bits6:0 = g..a
//             anodes     - active-low digit selects
//  Revision : 1.0 - initial release
// ============================================================================
module sseg_scan_ctrl #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit HEX_EN       = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_i,
  input  logic [3:0]  en_i,
  input  logic        lzb_i,
  input  logic        load_i,
  output logic        load_ack_o,
  output logic        frame_o,
  output logic [7:0]  sseg_o,
  output logic [3:0]  anodes
);

  localparam int            c_cw      = $clog2(DIGIT_CYCLES);
  localparam logic [c_cw-1:0] c_cnt_max = c_cw'(DIGIT_CYCLES - 1);
  localparam logic [c_cw-1:0] c_blank   = c_cw'(BLANK_CYCLES);

  // Scan position
  logic [c_cw-1:0] r_cnt;
  logic [1:0]      r_idx;

  // Staging (written by load) and display (visible) content
  logic [15:0] r_stg_val;
  logic [3:0]  r_stg_dp;
  logic [3:0]  r_stg_en;
  logic        r_stg_lzb;
  logic        r_pend;

  logic [15:0] r_val;
  logic [3:0]  r_dp;
  logic [3:0]  r_en;
  logic        r_lzb;

  logic            w_cnt_wrap;
  logic            w_boundary;
  logic            w_apply;
  logic [c_cw-1:0] w_cnt_nxt;
  logic [1:0]      w_idx_nxt;
  logic [15:0]     w_val_nxt;
  logic [3:0]      w_dp_nxt;
  logic [3:0]      w_en_nxt;
  logic            w_lzb_nxt;
  logic [3:0]      w_nib;
  logic [3:0]      w_lzblank;
  logic            w_lit;
  logic            w_show;
  logic [6:0]      w_seg7;
  logic [7:0]      w_sseg_nxt;
  logic [3:0]      w_anodes_nxt;

  assign w_cnt_wrap = (r_cnt == c_cnt_max);
  assign w_boundary = w_cnt_wrap && (r_idx == 2'd3);
  assign w_cnt_nxt  = w_cnt_wrap ? '0 : r_cnt + 1'b1;
  assign w_idx_nxt  = w_cnt_wrap ? r_idx + 2'd1 : r_idx;

  // A load on the boundary cycle itself bypasses staging and goes live now.
  assign w_apply   = w_boundary && (r_pend || load_i);
  assign w_val_nxt = w_apply ? (load_i ? value_i : r_stg_val) : r_val;
  assign w_dp_nxt  = w_apply ? (load_i ? dp_i    : r_stg_dp)  : r_dp;
  assign w_en_nxt  = w_apply ? (load_i ? en_i    : r_stg_en)  : r_en;
  assign w_lzb_nxt = w_apply ? (load_i ? lzb_i   : r_stg_lzb) : r_lzb;

  // Outputs are registered from next-state values so that the registered
  // outputs line up with the registered scan position.
  assign w_nib = w_val_nxt[{w_idx_nxt, 2'b00} +: 4];

  // Blanking ripples down from the most significant digit; digit 0 always shows.
  assign w_lzblank[3] = w_lzb_nxt && (w_val_nxt[15:12] == 4'h0);
  assign w_lzblank[2] = w_lzblank[3] && (w_val_nxt[11:8] == 4'h0);
  assign w_lzblank[1] = w_lzblank[2] && (w_val_nxt[7:4] == 4'h0);
  assign w_lzblank[0] = 1'b0;

  assign w_lit  = w_en_nxt[w_idx_nxt] && !w_lzblank[w_idx_nxt];
  assign w_show = (w_cnt_nxt >= c_blank) && w_lit;

  always_comb begin
    w_seg7 = 7'h7F;
    case (w_nib)
      4'h0: w_seg7 = 7'h40;
      4'h1: w_seg7 = 7'h79;
      4'h2: w_seg7 = 7'h24;
      4'h3: w_seg7 = 7'h30;
      4'h4: w_seg7 = 7'h19;
      4'h5: w_seg7 = 7'h12;
      4'h6: w_seg7 = 7'h02;
      4'h7: w_seg7 = 7'h78;
      4'h8: w_seg7 = 7'h00;
      4'h9: w_seg7 = 7'h10;
      4'hA: w_seg7 = HEX_EN ? 7'h08 : 7'h7F;
      4'hB: w_seg7 = HEX_EN ? 7'h03 : 7'h7F;
      4'hC: w_seg7 = HEX_EN ? 7'h46 : 7'h7F;
      4'hD: w_seg7 = HEX_EN ? 7'h21 : 7'h7F;
      4'hE: w_seg7 = HEX_EN ? 7'h06 : 7'h7F;
      4'hF: w_seg7 = HEX_EN ? 7'h0E : 7'h7F;
      default: w_seg7 = 7'h7F;
    endcase
  end

  always_comb begin
    w_sseg_nxt   = 8'hFF;
    w_anodes_nxt = 4'hF;
    if (w_show) begin
      w_sseg_nxt   = {~w_dp_nxt[w_idx_nxt], w_seg7};
      w_anodes_nxt = ~(4'b0001 << w_idx_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_idx      <= 2'd0;
      r_stg_val  <= 16'h0000;
      r_stg_dp   <= 4'h0;
      r_stg_en   <= 4'h0;
      r_stg_lzb  <= 1'b0;
      r_pend     <= 1'b0;
      r_val      <= 16'h0000;
      r_dp       <= 4'h0;
      r_en       <= 4'h0;
      r_lzb      <= 1'b0;
      anodes     <= 4'hF;
      sseg_o     <= 8'hFF;
      load_ack_o <= 1'b0;
      frame_o    <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_idx <= w_idx_nxt;

      if (load_i && !w_boundary) begin
        r_stg_val <= value_i;
        r_stg_dp  <= dp_i;
        r_stg_en  <= en_i;
        r_stg_lzb <= lzb_i;
        r_pend    <= 1'b1;
      end else if (w_boundary) begin
        r_pend <= 1'b0;
      end

      r_val <= w_val_nxt;
      r_dp  <= w_dp_nxt;
      r_en  <= w_en_nxt;
      r_lzb <= w_lzb_nxt;

      anodes     <= w_anodes_nxt;
      sseg_o     <= w_sseg_nxt;
      load_ack_o <= w_apply;
      frame_o    <= w_boundary;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sseg_scan_ctrl
//  Purpose  : Self-checking bench for sseg_scan_ctrl. Two instances (hex
//             decoding on and off) share all inputs. Expected per-cycle
//             anode/segment words for a whole frame are queued when content
//             is loaded and compared cycle by cycle from the frame pulse on.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_ctrl;

  localparam int DC = 8;
  localparam int BC = 2;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic [15:0] value_i = 16'h0000;
  logic [3:0]  dp_i    = 4'h0;
  logic [3:0]  en_i    = 4'h0;
  logic        lzb_i   = 1'b0;
  logic        load_i  = 1'b0;

  logic       ack1, frame1, ack0, frame0;
  logic [7:0] sseg1, sseg0;
  logic [3:0] an1, an0;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .HEX_EN(1'b1)) u_dut_hex (
    .clk(clk), .rst_n(rst_n), .value_i(value_i), .dp_i(dp_i), .en_i(en_i),
    .lzb_i(lzb_i), .load_i(load_i), .load_ack_o(ack1), .frame_o(frame1),
    .sseg_o(sseg1), .anodes(an1)
  );

  sseg_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .HEX_EN(1'b0)) u_dut_nohex (
    .clk(clk), .rst_n(rst_n), .value_i(value_i), .dp_i(dp_i), .en_i(en_i),
    .lzb_i(lzb_i), .load_i(load_i), .load_ack_o(ack0), .frame_o(frame0),
    .sseg_o(sseg0), .anodes(an0)
  );

  typedef struct packed {
    logic [11:0] h1;  // {anodes, sseg} expected from the hex instance
    logic [11:0] h0;  // {anodes, sseg} expected from the non-hex instance
  } exp_t;

  exp_t q_exp[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en,
                         input logic lzb);
    value_i = v;
    dp_i    = dp;
    en_i    = en;
    lzb_i   = lzb;
    load_i  = 1'b1;
    tick();
    load_i  = 1'b0;
  endtask

  // s1/s0 hold the lit segment byte of each digit as {d3,d2,d1,d0}.
  task automatic push_frame(input logic [31:0] s1, input logic [31:0] s0, input logic [3:0] lit);
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < DC; c++) begin
        if (c < BC || !lit[d]) begin
          e.h1 = 12'hFFF;
          e.h0 = 12'hFFF;
        end else begin
          e.h1 = {~(4'b0001 << d), s1[d*8 +: 8]};
          e.h0 = {~(4'b0001 << d), s0[d*8 +: 8]};
        end
        q_exp.push_back(e);
      end
    end
  endtask

  task automatic wait_frame();
    int k = 0;
    while (!frame1 && k < 40) begin
      tick();
      k++;
    end
    check("frame_seen", {frame1, frame0}, 2'b11);
  endtask

  // Checks one full frame starting at the frame pulse. With mid set, two
  // loads are issued during slots 1 and 2 of this frame.
  task automatic check_frame(input logic exp_ack, input bit mid);
    exp_t e;
    wait_frame();
    check("ack_at_boundary", {ack1, ack0}, {exp_ack, exp_ack});
    for (int i = 0; i < 4 * DC; i++) begin
      if (q_exp.size() == 0) begin
        check("queue_underflow", 1, 0);
        e = '1;
      end else begin
        e = q_exp.pop_front();
      end
      check($sformatf("hex_out i=%0d", i),   {an1, sseg1}, e.h1);
      check($sformatf("nohex_out i=%0d", i), {an0, sseg0}, e.h0);
      if (i > 0) check($sformatf("no_pulse i=%0d", i), {frame1, ack1, frame0, ack0}, 4'b0000);
      if (mid && i == 10) begin
        value_i = 16'h1111; dp_i = 4'h0; en_i = 4'hF; lzb_i = 1'b0; load_i = 1'b1;
      end
      if (mid && i == 18) begin
        value_i = 16'h2222; dp_i = 4'h0; en_i = 4'hF; lzb_i = 1'b0; load_i = 1'b1;
      end
      tick();
      load_i = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check("reset_hex",   {an1, sseg1, ack1, frame1}, {4'hF, 8'hFF, 2'b00});
    check("reset_nohex", {an0, sseg0, ack0, frame0}, {4'hF, 8'hFF, 2'b00});
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // No load yet: frames stay dark, no ack
    push_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0000);
    check_frame(1'b0, 1'b0);

    // Plain digits 1234
    do_load(16'h1234, 4'h0, 4'hF, 1'b0);
    push_frame({8'hF9, 8'hA4, 8'hB0, 8'h99}, {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'b1111);
    check_frame(1'b1, 1'b0);

    // Leading-zero blanking 0050
    do_load(16'h0050, 4'h0, 4'hF, 1'b1);
    push_frame({8'hFF, 8'hFF, 8'h92, 8'hC0}, {8'hFF, 8'hFF, 8'h92, 8'hC0}, 4'b0011);
    check_frame(1'b1, 1'b0);

    // All zero with blanking: only digit 0
    do_load(16'h0000, 4'h0, 4'hF, 1'b1);
    push_frame({8'hFF, 8'hFF, 8'hFF, 8'hC0}, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, 4'b0001);
    check_frame(1'b1, 1'b0);

    // Mid-frame loads leave this frame untouched; last load wins next frame
    push_frame({8'hFF, 8'hFF, 8'hFF, 8'hC0}, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, 4'b0001);
    check_frame(1'b0, 1'b1);
    push_frame({4{8'hA4}}, {4{8'hA4}}, 4'b1111);
    check_frame(1'b1, 1'b0);
    push_frame({4{8'hA4}}, {4{8'hA4}}, 4'b1111);
    check_frame(1'b0, 1'b0);

    // Hex digits with dp on digit 0
    do_load(16'hABCD, 4'b0001, 4'hF, 1'b0);
    push_frame({8'h88, 8'h83, 8'hC6, 8'h21}, {8'hFF, 8'hFF, 8'hFF, 8'h7F}, 4'b1111);
    check_frame(1'b1, 1'b0);

    // Sparse enables
    do_load(16'h8888, 4'h0, 4'b0101, 1'b0);
    push_frame({8'hFF, 8'h80, 8'hFF, 8'h80}, {8'hFF, 8'h80, 8'hFF, 8'h80}, 4'b0101);
    check_frame(1'b1, 1'b0);

    // Load on the boundary cycle itself (idx=3, cnt=DC-1); blanked digit 3 hides its dp
    repeat (4 * DC - 1) tick();
    do_load(16'h0987, 4'b1000, 4'hF, 1'b1);
    push_frame({8'hFF, 8'h90, 8'h80, 8'hF8}, {8'hFF, 8'h90, 8'h80, 8'hF8}, 4'b0111);
    check_frame(1'b1, 1'b0);

    // Asynchronous reset in the middle of a lit slot
    repeat (3) tick();
    check("lit_before_reset", {an1, sseg1}, {4'b1110, 8'hF8});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_hex",   {an1, sseg1, ack1, frame1}, {4'hF, 8'hFF, 2'b00});
    check("async_reset_nohex", {an0, sseg0, ack0, frame0}, {4'hF, 8'hFF, 2'b00});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    push_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0000);
    check_frame(1'b0, 1'b0);

    check("queue_empty", q_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
